// File: rtl/register_file_param.sv
// Parametrised ARM register file: three async read ports, one write port and a PC register
// with load/increment. Define REGFILE_WR_BYPASS_EN for same-cycle write-through on the read ports.
module register_file_param #(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       PC_IDX   = 15,
    parameter int unsigned       PC_STEP  = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              Enable,
    input  logic [ADDR_W-1:0] AddressIn,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] AddressOutA,
    input  logic [ADDR_W-1:0] AddressOutB,
    input  logic [ADDR_W-1:0] AddressOutC,
    output logic [DATA_W-1:0] DataOutA,
    output logic [DATA_W-1:0] DataOutB,
    output logic [DATA_W-1:0] DataOutC,
    input  logic              PcLoad,
    input  logic [DATA_W-1:0] PcIn,
    input  logic              PcInc,
    output logic [DATA_W-1:0] PcOut
);

    localparam int unsigned       NumRegs = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PcAddr  = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PcStep  = DATA_W'(PC_STEP);

    logic [DATA_W-1:0] regs_q [NumRegs];
    logic [DATA_W-1:0] regs_d [NumRegs];

    logic              pc_wr_hit;
    logic [ADDR_W-1:0] rd_addr [3];
    logic [DATA_W-1:0] rd_data [3];

    assign pc_wr_hit = Enable && (AddressIn == PcAddr);

    always_comb begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (Clr) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_d[i] = '0;
            end
            regs_d[PcAddr] = RESET_PC;
        end else begin
            if (Enable) begin
                regs_d[AddressIn] = DataIn;
            end
            // An explicit write to the PC wins; a losing load/increment is dropped.
            if (!pc_wr_hit) begin
                if (PcLoad) begin
                    regs_d[PcAddr] = PcIn;
                end else if (PcInc) begin
                    regs_d[PcAddr] = regs_q[PcAddr] + PcStep;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        for (int unsigned i = 0; i < NumRegs; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    assign rd_addr[0] = AddressOutA;
    assign rd_addr[1] = AddressOutB;
    assign rd_addr[2] = AddressOutC;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
`ifdef REGFILE_WR_BYPASS_EN
            if (Enable && !Clr && (rd_addr[p] == AddressIn)) begin
                rd_data[p] = DataIn;
            end
`endif
        end
    end

    assign DataOutA = rd_data[0];
    assign DataOutB = rd_data[1];
    assign DataOutC = rd_data[2];
    assign PcOut    = regs_q[PcAddr];

endmodule

// File: doc/register_file_param.md
Name: register_file_param

Overview:
- Parametrised successor register file for the ARM datapath: NUM_REGS x DATA_W storage, one write port, three asynchronous read ports (Rn, Rm, Rs operands).
- Dedicated program-counter register at index PC_IDX, with its own load and auto-increment path.
- Sits between the decode stage (addresses) and the ALU/shifter (operands); the fetch stage drives the PC controls.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 4, address width; NUM_REGS = 2**ADDR_W
- PC_IDX, 15, index of the program-counter register (must be < NUM_REGS)
- PC_STEP, 4, PC increment per PcInc cycle
- RESET_PC, 0, value loaded into the PC register on reset

Ports:
- Clk  in  1  clock; all state updates on rising edge
- Clr  in  1  synchronous reset, active-high
- Enable  in  1  write enable, active-high
- AddressIn  in  ADDR_W  write address
- DataIn  in  DATA_W  write data
- AddressOutA  in  ADDR_W  read address port A
- AddressOutB  in  ADDR_W  read address port B
- AddressOutC  in  ADDR_W  read address port C
- DataOutA  out  DATA_W  read data port A
- DataOutB  out  DATA_W  read data port B
- DataOutC  out  DATA_W  read data port C
- PcLoad  in  1  load PcIn into the PC register
- PcIn  in  DATA_W  PC load value (branch target)
- PcInc  in  1  advance PC by PC_STEP
- PcOut  out  DATA_W  current PC register value, always visible

Behaviour:
- Reset: Clk and Clr are the only clock and reset. Reset is synchronous and active-high. On a rising Clk edge with Clr=1:
  - every register except PC_IDX becomes 0; the PC register becomes RESET_PC;
  - all other inputs are ignored that cycle.
  - After reset, PcOut=RESET_PC and DataOutX=0 for any non-PC address.
- Reset mid-operation: Clr dominates any simultaneous Enable, PcLoad or PcInc; no partial write occurs.
- Reads: purely combinational. DataOutX = reg[AddressOutX] within the same cycle, zero latency. Two or three ports may address the same register.
- Write: on a rising edge with Enable=1, reg[AddressIn] <= DataIn. Visible on the read ports from the next cycle (see Optional Feature for same-cycle visibility).
- PC register update, evaluated each rising edge when Clr=0, highest priority first:
  1. Enable=1 and AddressIn==PC_IDX: PC <= DataIn (explicit write to R15).
  2. PcLoad=1: PC <= PcIn.
  3. PcInc=1: PC <= PC + PC_STEP, modulo 2**DATA_W. Wrap example: 0xFFFFFFFC + 4 = 0x00000000, with no carry or flag.
  4. Otherwise PC holds.
- When PcLoad or PcInc loses to a higher-priority source, it is dropped, not deferred.
- Enable=1 to a non-PC address alongside PcLoad or PcInc: both updates occur in the same edge.
- Reading address PC_IDX on any port returns the PC register; PcOut always equals reg[PC_IDX].
- All registers hold their value when Enable=0, PcLoad=0 and PcInc=0.
- Out-of-range addresses are impossible by construction (NUM_REGS = 2**ADDR_W).

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN
- Defined: write-through forwarding. When Enable=1 and AddressOutX==AddressIn, DataOutX = DataIn combinationally in that same cycle.
  - For AddressIn==PC_IDX, bypass returns DataIn; PcOut is not bypassed.
  - No bypass while Clr=1.
- Not defined: read ports always return stored contents; a same-cycle write appears only after the edge.

Test Plan:
- Reset: Clr=1 for 1 cycle with Enable=1, AddressIn=3, DataIn=0xDEADBEEF -> R3=0, all DataOut=0 for non-PC addresses, PcOut=RESET_PC=0.
- Write/read all: write R0..R14 with 0x1000+i -> ports A/B/C read back 0x1000+i, including all three ports on the same address and three different addresses in one cycle.
- PC priority: PcInc=1, PcLoad=1, PcIn=0x200, Enable=1, AddressIn=15, DataIn=0x300 -> PcOut=0x300. Next cycle PcLoad=1, PcInc=1 -> 0x200. Next cycle PcInc only -> 0x204.
- PC wrap: PcLoad with PcIn=0xFFFFFFFC, then PcInc -> PcOut=0x00000000.
- Concurrent updates: Enable=1, AddressIn=5, DataIn=0xA5A5A5A5 while PcInc=1 from PC=0x10 -> R5=0xA5A5A5A5 and PcOut=0x14 after the edge.
- Bypass: AddressOutA=7, Enable=1, AddressIn=7, DataIn=0x55 with old R7=0x11 -> before the edge DataOutA=0x55 with REGFILE_WR_BYPASS_EN defined, 0x11 without it. After the edge it reads 0x55 in both builds.
